// File: rtl/ysyx_23060208_ifu_pkg.sv
// Shared IFU definitions: bus widths, reset PC, AXI read constants and FSM encoding.
package ysyx_23060208_ifu_pkg;

  localparam int          EXU_TO_IFU_BUS   = 33;
  localparam int          IFU_TO_IDU_BUS   = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [7:0]  AXI_LEN_SINGLE = 8'h00;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_FIX  = 2'b00;
  localparam logic [1:0]  AXI_RESP_DEC   = 2'b11;

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_AR       = 3'd1,
    S_R        = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT_EXU = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060208_ifu_perf.sv
// IFU performance counters: completed fetches and AR/R stall cycles, wrapping at 2^32.
module ysyx_23060208_ifu_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_fetch,
  input  logic        i_stall,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/ysyx_23060208_ifu.sv
// Multicycle instruction fetch: one AXI4 single-beat read per round, hand-off to IDU, next PC from EXU.
// Optional macro IFU_PERF_CNT_EN adds fetch/stall counter outputs.
module ysyx_23060208_ifu
  import ysyx_23060208_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter logic [3:0]            ARID_VAL   = 4'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      isram_arvalid,
  input  logic                      isram_arready,
  output logic [DATA_WIDTH-1:0]     isram_araddr,
  output logic [3:0]                isram_arid,
  output logic [7:0]                isram_arlen,
  output logic [2:0]                isram_arsize,
  output logic [1:0]                isram_arburst,
  input  logic                      isram_rvalid,
  output logic                      isram_rready,
  input  logic [2*DATA_WIDTH-1:0]   isram_rdata,
  input  logic [1:0]                isram_rresp,
  input  logic                      isram_rlast,
  input  logic [3:0]                isram_rid,
  output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
  output logic                      ifu_to_idu_valid,
  input  logic                      idu_allowin,
  input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
  input  logic                      exu_to_ifu_valid,
  output logic                      ifu_access_fault,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]               ifu_fetch_cnt,
  output logic [31:0]               ifu_stall_cnt,
`endif
  output ifu_state_e                ifu_dbg_state
);

  // Handshakes: a transfer happens on any clock edge where valid && ready
  // (AR: arvalid/arready, R: rvalid/rready, IDU: valid/allowin); once raised,
  // valid and its payload stay stable until that edge.

  ifu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_valid;
  logic                  r_fault;

  logic                  w_beat_ok;
  logic [DATA_WIDTH-1:0] w_inst;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_nextpc;
  logic                  w_unused;

  assign w_beat_ok = isram_rvalid && (isram_rid == ARID_VAL);
  assign w_inst    = r_pc[2] ? isram_rdata[2*DATA_WIDTH-1:DATA_WIDTH] : isram_rdata[DATA_WIDTH-1:0];
  assign w_taken   = exu_to_ifu_bus[DATA_WIDTH];
  assign w_nextpc  = exu_to_ifu_bus[DATA_WIDTH-1:0];
  // Single-beat reads, so rlast carries no information.
  assign w_unused  = isram_rlast;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      unique case (r_state)
        S_BOOT: begin
          r_arvalid <= 1'b1;
          r_state   <= S_AR;
        end
        S_AR: if (isram_arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_R;
        end
        // Beats tagged with a foreign id are accepted (rready high) but dropped.
        S_R: if (w_beat_ok) begin
          r_inst   <= w_inst;
          r_fault  <= (isram_rresp == AXI_RESP_DEC);
          r_rready <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: if (idu_allowin) begin
          r_valid <= 1'b0;
          r_state <= S_WAIT_EXU;
        end
        S_WAIT_EXU: if (exu_to_ifu_valid) begin
          r_pc      <= w_taken ? w_nextpc : r_pc + DATA_WIDTH'(4);
          r_arvalid <= 1'b1;
          r_state   <= S_AR;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign isram_arvalid    = r_arvalid;
  assign isram_araddr     = r_pc;
  assign isram_arid       = ARID_VAL;
  assign isram_arlen      = AXI_LEN_SINGLE;
  assign isram_arsize     = AXI_SIZE_4B;
  assign isram_arburst    = AXI_BURST_FIX;
  assign isram_rready     = r_rready;
  assign ifu_to_idu_bus   = {r_pc, r_inst};
  assign ifu_to_idu_valid = r_valid;
  assign ifu_access_fault = r_fault;
  assign ifu_dbg_state    = r_state;

`ifdef IFU_PERF_CNT_EN
  logic w_fetch;
  logic w_stall;

  assign w_fetch = (r_state == S_R) && w_beat_ok;
  assign w_stall = ((r_state == S_AR) && !isram_arready) || ((r_state == S_R) && !w_beat_ok);

  ysyx_23060208_ifu_perf u_perf (
    .clock       (clock),
    .reset       (reset),
    .i_fetch     (w_fetch),
    .i_stall     (w_stall),
    .o_fetch_cnt (ifu_fetch_cnt),
    .o_stall_cnt (ifu_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Bench for ysyx_23060208_ifu: AXI slave and IDU/EXU drivers push expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_ysyx_23060208_ifu;
  import ysyx_23060208_ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          N      = 40;
  localparam int          TMO    = 200;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        isram_arvalid, isram_arready;
  logic [31:0] isram_araddr;
  logic [3:0]  isram_arid;
  logic [7:0]  isram_arlen;
  logic [2:0]  isram_arsize;
  logic [1:0]  isram_arburst;
  logic        isram_rvalid, isram_rready, isram_rlast;
  logic [63:0] isram_rdata;
  logic [1:0]  isram_rresp;
  logic [3:0]  isram_rid;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid, idu_allowin;
  logic [32:0] exu_to_ifu_bus;
  logic        exu_to_ifu_valid, ifu_access_fault;
  ifu_state_e  ifu_dbg_state;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] ifu_fetch_cnt, ifu_stall_cnt;
`endif

  ysyx_23060208_ifu dut (
    .clock            (clock),
    .reset            (reset),
    .isram_arvalid    (isram_arvalid),
    .isram_arready    (isram_arready),
    .isram_araddr     (isram_araddr),
    .isram_arid       (isram_arid),
    .isram_arlen      (isram_arlen),
    .isram_arsize     (isram_arsize),
    .isram_arburst    (isram_arburst),
    .isram_rvalid     (isram_rvalid),
    .isram_rready     (isram_rready),
    .isram_rdata      (isram_rdata),
    .isram_rresp      (isram_rresp),
    .isram_rlast      (isram_rlast),
    .isram_rid        (isram_rid),
    .ifu_to_idu_bus   (ifu_to_idu_bus),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .idu_allowin      (idu_allowin),
    .exu_to_ifu_bus   (exu_to_ifu_bus),
    .exu_to_ifu_valid (exu_to_ifu_valid),
    .ifu_access_fault (ifu_access_fault),
`ifdef IFU_PERF_CNT_EN
    .ifu_fetch_cnt    (ifu_fetch_cnt),
    .ifu_stall_cnt    (ifu_stall_cnt),
`endif
    .ifu_dbg_state    (ifu_dbg_state)
  );

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_bus_q[$];
  logic        exp_fault_q[$];
  int          exp_stall = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_pc;

  int          ar_d_a[N], r_d_a[N], idu_d_a[N], exu_d_a[N];
  bit          bad_a[N];
  logic [1:0]  resp_a[N];

  logic        p_arv, p_arr, p_v, p_al;
  logic [31:0] p_addr;
  logic [63:0] p_bus;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory image: a fixed line at the reset PC, an address hash elsewhere.
  function automatic logic [63:0] mem_line(input logic [31:0] a);
    if (a[31:3] == RST_PC[31:3]) return 64'h0000_0013_0010_0093;
    return {({a[31:3], 3'b000} ^ 32'h0F0F_0F0F), ({a[31:3], 3'b000} ^ 32'hC3C3_3C3C)};
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    logic [63:0] line;
    line = mem_line(pc);
    return pc[2] ? line[63:32] : line[31:0];
  endfunction

  // monitor
  initial begin
    p_arv = 1'b0; p_arr = 1'b0; p_v = 1'b0; p_al = 1'b0; p_addr = '0; p_bus = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (p_arv && !p_arr) begin
          check("ar_hold_valid", isram_arvalid, 1);
          check("ar_hold_addr", isram_araddr, p_addr);
        end
        if (isram_arvalid && isram_arready) begin
          check("ar_fields", {isram_arid, isram_arlen, isram_arsize, isram_arburst},
                {4'h0, 8'h00, 3'b010, 2'b00});
          if (exp_addr_q.size() == 0) check("ar_unexpected", 1, 0);
          else check("araddr", isram_araddr, exp_addr_q.pop_front());
        end
        if (ifu_to_idu_valid && !p_v) begin
          if (exp_fault_q.size() == 0) check("fetch_unexpected", 1, 0);
          else check("fault", ifu_access_fault, exp_fault_q.pop_front());
        end else begin
          check("fault_idle", ifu_access_fault, 0);
        end
        if (p_v && !p_al) begin
          check("idu_hold_valid", ifu_to_idu_valid, 1);
          check("idu_hold_bus", ifu_to_idu_bus, p_bus);
        end
        if (ifu_to_idu_valid && idu_allowin) begin
          if (exp_bus_q.size() == 0) check("idu_unexpected", 1, 0);
          else check("idu_bus", ifu_to_idu_bus, exp_bus_q.pop_front());
        end
      end
      p_arv = isram_arvalid; p_arr = isram_arready; p_addr = isram_araddr;
      p_v = ifu_to_idu_valid; p_al = idu_allowin; p_bus = ifu_to_idu_bus;
    end
  end

  // AXI read slave driver
  task automatic slave_proc();
    for (int r = 0; r < N; r++) begin
      int t;
      logic [31:0] a;
      t = 0;
      while (!isram_arvalid && t < TMO) begin tick(); t++; end
      if (t >= TMO) begin check("ar_timeout", 0, 1); return; end
      repeat (ar_d_a[r]) tick();
      a = isram_araddr;
      isram_arready = 1'b1; tick(); isram_arready = 1'b0;
      exp_stall += ar_d_a[r] + r_d_a[r] + (bad_a[r] ? 1 : 0);
      repeat (r_d_a[r]) tick();
      if (bad_a[r]) begin
        isram_rvalid = 1'b1; isram_rid = 4'h3; isram_rdata = {$urandom, $urandom}; isram_rresp = 2'b11;
        tick();
      end
      isram_rvalid = 1'b1; isram_rid = 4'h0; isram_rdata = mem_line(a); isram_rresp = resp_a[r];
      isram_rlast = 1'b1;
      exp_fault_q.push_back(resp_a[r] == 2'b11);
      tick();
      isram_rvalid = 1'b0; isram_rlast = 1'b0; isram_rresp = 2'b00;
    end
  endtask

  // IDU + EXU driver; owns the reference PC model
  task automatic down_proc();
    for (int r = 0; r < N; r++) begin
      int t;
      logic tk;
      logic [31:0] np;
      t = 0;
      while (!ifu_to_idu_valid && t < TMO) begin tick(); t++; end
      if (t >= TMO) begin check("idu_timeout", 0, 1); return; end
      if (r == 3) begin
        exu_to_ifu_valid = 1'b1; exu_to_ifu_bus = {1'b1, 32'h1234_5678};
        tick(); exu_to_ifu_valid = 1'b0;
      end
      repeat (idu_d_a[r]) tick();
      idu_allowin = 1'b1; tick(); idu_allowin = 1'b0;
      repeat (exu_d_a[r]) tick();
      case (r)
        0:       begin tk = 1'b0; np = $urandom; end
        1:       begin tk = 1'b1; np = 32'h8000_0100; end
        4:       begin tk = 1'b1; np = 32'hFFFF_FFFC; end
        5:       begin tk = 1'b0; np = $urandom; end
        6:       begin tk = 1'b1; np = 32'h8000_1003; end
        default: begin tk = 1'($urandom_range(0, 1)); np = $urandom; end
      endcase
      model_pc = tk ? np : model_pc + 32'd4;
      exp_addr_q.push_back(model_pc);
      if (r < N - 1) exp_bus_q.push_back({model_pc, inst_of(model_pc)});
      exu_to_ifu_valid = 1'b1; exu_to_ifu_bus = {tk, np};
      tick();
      exu_to_ifu_valid = 1'b0;
    end
  endtask

  initial begin
    isram_arready = 1'b0; isram_rvalid = 1'b0; isram_rdata = '0; isram_rresp = 2'b00;
    isram_rlast = 1'b0; isram_rid = 4'h0; idu_allowin = 1'b0;
    exu_to_ifu_bus = '0; exu_to_ifu_valid = 1'b0;

    for (int r = 0; r < N; r++) begin
      ar_d_a[r]  = $urandom_range(0, 3);
      r_d_a[r]   = $urandom_range(0, 3);
      bad_a[r]   = ($urandom_range(0, 4) == 0);
      resp_a[r]  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      idu_d_a[r] = $urandom_range(0, 3);
      exu_d_a[r] = $urandom_range(0, 3);
    end
    for (int r = 0; r < 2; r++) begin
      ar_d_a[r] = 0; r_d_a[r] = 0; bad_a[r] = 1'b0; resp_a[r] = 2'b00; idu_d_a[r] = 0; exu_d_a[r] = 0;
    end
    ar_d_a[2] = 5; r_d_a[2] = 0; bad_a[2] = 1'b0;
    idu_d_a[3] = 2;
    bad_a[4] = 1'b1; r_d_a[4] = 0; resp_a[4] = 2'b11;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_arvalid", isram_arvalid, 0);
    check("rst_rready", isram_rready, 0);
    check("rst_valid", ifu_to_idu_valid, 0);
    check("rst_fault", ifu_access_fault, 0);
    check("rst_bus", ifu_to_idu_bus, {RST_PC, 32'h0});
    check("rst_state", ifu_dbg_state, S_BOOT);

    model_pc = RST_PC;
    exp_addr_q.push_back(RST_PC);
    exp_bus_q.push_back({RST_PC, inst_of(RST_PC)});
    @(posedge clock); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    check("first_arvalid", isram_arvalid, 1);

    fork
      slave_proc();
      down_proc();
    join

`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", ifu_fetch_cnt, N);
    check("stall_cnt", ifu_stall_cnt, exp_stall);
`endif

    // Accept one more AR, then reset while the read is outstanding.
    isram_arready = 1'b1; tick(); isram_arready = 1'b0;
    check("in_r_state", ifu_dbg_state, S_R);
    mon_en = 1'b0;
    reset = 1'b0;
    tick();
    check("mid_rst_state", ifu_dbg_state, S_BOOT);
    check("mid_rst_pc", isram_araddr, RST_PC);
    check("mid_rst_valids", {isram_arvalid, isram_rready, ifu_to_idu_valid, ifu_access_fault}, 4'b0000);
`ifdef IFU_PERF_CNT_EN
    check("mid_rst_cnts", {ifu_fetch_cnt, ifu_stall_cnt}, 64'h0);
`endif
    reset = 1'b1;
    tick();
    check("rerun_arvalid", isram_arvalid, 1);
    check("queues_drained", {32'(exp_addr_q.size()), 16'(exp_bus_q.size()), 16'(exp_fault_q.size())}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
